iterative_muldiv_unit: RTL
==========================

// Module: iterative_muldiv_unit
//
// PURPOSE
//  Multi-cycle RV32M/RV64M multiply/divide unit replacing the single-cycle combinational
//  mul/div path of the datapath.
//  Takes two XLEN operands plus the M-extension funct3 through a valid/ready handshake.
//  Iterates UNROLL bits per cycle and holds the result until it is consumed.
//  Sits beside the ALU; the core stalls while in_ready is low.
//
// PARAMETERS
//  XLEN    32  operand/result width; must be 32 or 64
//  UNROLL  1   bits retired per CALC cycle; must divide XLEN (1,2,4,8)
//
// PORTS
//  SYS_clk      in   1     clock, all state updates on rising edge
//  SYS_reset_n  in   1     synchronous reset, active-low
//  kill         in   1     synchronous abort of any operation in flight
//  in_valid     in   1     request valid
//  in_ready     out  1     unit can accept; high only in IDLE
//  funct3       in   3     000 MUL, 001 MULH, 010 MULHSU, 011 MULHU,
//                          100 DIV, 101 DIVU, 110 REM, 111 REMU
//  op_a         in   XLEN  rs1 value (multiplicand / dividend)
//  op_b         in   XLEN  rs2 value (multiplier / divisor)
//  out_valid    out  1     result valid; held until out_ready
//  out_ready    in   1     consumer accepts result
//  result       out  XLEN  result; stable while out_valid is high
//  busy         out  1     high in CALC or DONE
//
// BEHAVIOUR
//  - Reset (SYS_reset_n=0 at an edge): state=IDLE, out_valid=0, result=0, busy=0,
//    internal regs=0. Reset has priority over every other input.
//  - in_ready = (state==IDLE) & ~kill. This is combinational from state and kill.
//  - States and transitions:
//    - IDLE: on in_valid&in_ready, capture funct3 and operands.
//      - Special case (div/rem with op_b==0, or signed DIV/REM with op_a==MIN_INT and
//        op_b==-1): go to DONE.
//      - Otherwise: go to CALC with cnt=XLEN/UNROLL.
//    - CALC: retire UNROLL bits per cycle and decrement cnt. When cnt reaches 1, go to
//      DONE next edge with result registered and out_valid=1.
//    - DONE: out_valid=1. On out_ready, go to IDLE and set out_valid=0.
//      No new accept occurs in this same cycle.
//  - Latency, accept edge to out_valid high:
//    - normal ops: XLEN/UNROLL+1 cycles;
//    - special cases: 1 cycle.
//  - Multiply uses shift-add on a 2*XLEN product.
//    - Operands are sign-extended to XLEN+1 as follows: MULH signs both,
//      MULHSU signs op_a only, MULHU and MUL sign neither.
//    - MUL returns product[XLEN-1:0]. MULH, MULHSU and MULHU return product[2*XLEN-1:XLEN].
//  - Divide uses restoring division on magnitudes.
//    - Signed ops: quotient negated if sign(a)!=sign(b); remainder takes the sign of a.
//  - Special results:
//    - b==0: DIV/DIVU give all ones, REM/REMU give op_a.
//    - Signed overflow: DIV gives MIN_INT, REM gives 0.
//  - Operands are registered at accept. Changes on op_a/op_b/funct3 after accept have no effect.
//  - kill=1: next edge returns to IDLE with out_valid=0; the result is discarded.
//    kill with in_valid in the same cycle: no accept.
//  - in_valid while busy: ignored, no side effect.
//  - Reset mid-CALC/DONE: same as the reset values above; no out_valid pulse.
//  - result holds its last value in IDLE. It is only guaranteed while out_valid=1.
//
// TESTING
//  - MUL 7 * -3 (XLEN=32, UNROLL=1): accept at t0 -> out_valid at t0+33,
//    result=32'hFFFF_FFEB, held until out_ready.
//  - MULH / MULHSU / MULHU with a=32'h8000_0000, b=32'hFFFF_FFFF
//    -> 32'h0000_0000 / 32'h8000_0000 / 32'h7FFF_FFFF.
//  - Special cases, each out_valid at t0+1:
//    - DIVU 100 / 0 -> 32'hFFFF_FFFF; REM 100 / 0 -> 100;
//    - DIV 32'h8000_0000 / -1 -> 32'h8000_0000; REM same operands -> 0.
//  - DIV -7 / 2 -> 32'hFFFF_FFFD; REM -7 / 2 -> 32'hFFFF_FFFF; DIVU 32'hFFFF_FFFF / 16 -> 32'h0FFF_FFFF.
//    Repeat all with UNROLL=4: latency 9.
//  - Handshake:
//    - Hold out_ready=0 for 5 cycles -> out_valid and result stay stable.
//    - in_valid pulses during CALC are ignored.
//    - out_ready edge -> in_ready high on the next cycle.
//  - Abort:
//    - kill at CALC cycle 10 -> IDLE next edge, no out_valid.
//    - SYS_reset_n=0 during DONE -> out_valid=0, result=0.
//    - A new MUL 3*5 afterwards -> 15.

Source files
------------

// File: rtl/iterative_muldiv_unit.sv
// Multi-cycle RV32M/RV64M multiply/divide unit: shift-add multiply and restoring
// divide on operand magnitudes, UNROLL bits per cycle, valid/ready on both sides.
module iterative_muldiv_unit #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned UNROLL = 1
) (
  input  logic            SYS_clk,
  input  logic            SYS_reset_n,
  input  logic            kill,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int unsigned STEPS = XLEN / UNROLL;
  localparam int unsigned CW    = $clog2(STEPS + 1);
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [XLEN-1:0] hi, hi_nxt;
  logic [XLEN-1:0] lo, lo_nxt;
  logic [XLEN-1:0] dsr, dsr_nxt;
  logic [2:0]      op, op_nxt;
  logic            neg_q, neg_q_nxt;
  logic            neg_r, neg_r_nxt;
  logic [XLEN-1:0] result_nxt;

  logic            accept;
  logic            is_div, div_signed, a_signed, b_signed, a_neg, b_neg;
  logic            div_by_zero, overflow, special;
  logic [XLEN-1:0] a_mag, b_mag, special_res;

  logic [XLEN-1:0]   h, l, step_hi, step_lo;
  logic [XLEN:0]     sum, sh;
  logic [2*XLEN-1:0] prod, prod_adj;
  logic [XLEN-1:0]   quo, rem, fin;

  assign in_ready  = (state == IDLE) & ~kill;
  assign accept    = in_valid & in_ready;
  assign out_valid = (state == DONE);
  assign busy      = (state == CALC) | (state == DONE);

  always_comb begin
    is_div      = funct3[2];
    div_signed  = funct3[2] & ~funct3[0];
    a_signed    = (funct3 == 3'b001) | (funct3 == 3'b010) | div_signed;
    b_signed    = (funct3 == 3'b001) | div_signed;
    a_neg       = a_signed & op_a[XLEN-1];
    b_neg       = b_signed & op_b[XLEN-1];
    a_mag       = a_neg ? -op_a : op_a;
    b_mag       = b_neg ? -op_b : op_b;
    div_by_zero = is_div & (op_b == '0);
    overflow    = div_signed & (op_a == MIN_INT) & (op_b == '1);
    special     = div_by_zero | overflow;
    if (div_by_zero) special_res = funct3[1] ? op_a : '1;
    else             special_res = funct3[1] ? '0 : MIN_INT;
  end

  // hi:lo is the running product (multiply) or remainder:quotient (divide);
  // lo starts as the multiplier / dividend magnitude and is shifted out as bits retire.
  always_comb begin
    h   = hi;
    l   = lo;
    sum = '0;
    sh  = '0;
    for (int unsigned i = 0; i < UNROLL; i++) begin
      if (!op[2]) begin
        sum = {1'b0, h} + (l[0] ? {1'b0, dsr} : '0);
        l   = {sum[0], l[XLEN-1:1]};
        h   = sum[XLEN:1];
      end else begin
        sh = {h, l[XLEN-1]};
        l  = {l[XLEN-2:0], 1'b0};
        if (sh >= {1'b0, dsr}) begin
          h    = sh[XLEN-1:0] - dsr;
          l[0] = 1'b1;
        end else begin
          h = sh[XLEN-1:0];
        end
      end
    end
    step_hi = h;
    step_lo = l;
  end

  always_comb begin
    prod     = {step_hi, step_lo};
    prod_adj = neg_q ? -prod : prod;
    quo      = neg_q ? -step_lo : step_lo;
    rem      = neg_r ? -step_hi : step_hi;
    if (op[2])                fin = op[1] ? rem : quo;
    else if (op[1:0] == 2'b00) fin = prod_adj[XLEN-1:0];
    else                      fin = prod_adj[2*XLEN-1:XLEN];
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    hi_nxt     = hi;
    lo_nxt     = lo;
    dsr_nxt    = dsr;
    op_nxt     = op;
    neg_q_nxt  = neg_q;
    neg_r_nxt  = neg_r;
    result_nxt = result;
    if (kill) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            op_nxt    = funct3;
            hi_nxt    = '0;
            lo_nxt    = a_mag;
            dsr_nxt   = b_mag;
            neg_q_nxt = a_neg ^ b_neg;
            neg_r_nxt = a_neg;
            if (special) begin
              result_nxt = special_res;
              state_nxt  = DONE;
            end else begin
              cnt_nxt   = CW'(STEPS);
              state_nxt = CALC;
            end
          end
        end
        CALC: begin
          hi_nxt  = step_hi;
          lo_nxt  = step_lo;
          cnt_nxt = cnt - CW'(1);
          if (cnt == CW'(1)) begin
            result_nxt = fin;
            state_nxt  = DONE;
          end
        end
        DONE: begin
          if (out_ready) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge SYS_clk) begin
    if (!SYS_reset_n) begin
      state  <= IDLE;
      cnt    <= '0;
      hi     <= '0;
      lo     <= '0;
      dsr    <= '0;
      op     <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      result <= '0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      hi     <= hi_nxt;
      lo     <= lo_nxt;
      dsr    <= dsr_nxt;
      op     <= op_nxt;
      neg_q  <= neg_q_nxt;
      neg_r  <= neg_r_nxt;
      result <= result_nxt;
    end
  end

endmodule
